memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: watchdog limit in cycles, range 2..255.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port resetN, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port fetchReq, input, 1 bit: instruction-fetch read request, held until fetchAck.
REQ-007 SHALL have port fetchAddr, input, ADDR_W bits: fetch address, stable while fetchReq is high.
REQ-008 SHALL have port fetchAck, output, 1 bit: one-cycle completion pulse for fetch.
REQ-009 SHALL have port fetchData, output, DATA_W bits: fetched word, valid when fetchAck is high.
REQ-010 SHALL have port dataReq, input, 1 bit: data-stage request, held until dataAck.
REQ-011 SHALL have port dataWrite, input, 1 bit: 1 = store, 0 = load.
REQ-012 SHALL have port dataAddr, input, ADDR_W bits: data address.
REQ-013 SHALL have port dataWriteData, input, DATA_W bits: store data.
REQ-014 SHALL have port dataAck, output, 1 bit: one-cycle completion pulse for data.
REQ-015 SHALL have port dataReadData, output, DATA_W bits: load result, valid when dataAck is high.
REQ-016 SHALL have port memReq, output, 1 bit: request to the shared memory, held until memReady.
REQ-017 SHALL have port memWrite, output, 1 bit: write strobe qualifying memReq.
REQ-018 SHALL have port memAddr, output, ADDR_W bits: memory address.
REQ-019 SHALL have port memWriteData, output, DATA_W bits: memory write data.
REQ-020 SHALL have port memReadData, input, DATA_W bits: memory read data, valid with memReady.
REQ-021 SHALL have port memReady, input, 1 bit: memory completion, sampled only while memReq is high.
REQ-022 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-023 SHALL have port timeoutError, output, 1 bit: pulses together with the ack of an aborted transaction.

Function
REQ-024 SHALL use FSM states IDLE, FETCH and DATA; all outputs SHALL be registered.
REQ-025 In IDLE with exactly one request pending, SHALL go to that requester's state at the next edge.
REQ-026 When both requests are pending in IDLE, SHALL grant the requester not granted last (lastGrant flag); lastGrant resets to FETCH, so data wins the first tie.
REQ-027 SHALL latch the address, write flag and write data at grant; memReq, memAddr, memWrite and memWriteData SHALL be driven from the cycle after the grant edge.
REQ-028 On memReady=1 in FETCH or DATA: SHALL capture memReadData, pulse the matching ack for exactly one cycle on the next edge, drop memReq, update lastGrant and return to IDLE.
REQ-029 Minimum latency from request to ack SHALL be 3 cycles with memReady=1 on first memReq cycle.
REQ-030 Back-to-back: a request still high in the ack cycle SHALL NOT be regranted; it is eligible one cycle later, from IDLE.
REQ-031 Store SHALL leave dataReadData unchanged; fetchData/dataReadData SHALL hold their values between acks.
REQ-032 fetchAck and dataAck SHALL never be high in the same cycle.
REQ-033 memReady while memReq is low SHALL be ignored.

Reset
REQ-034 With resetN=0 at an edge: state IDLE, lastGrant FETCH, all outputs 0, including data outputs and busy.
REQ-035 Reset mid-transaction SHALL abort it silently: memReq low after that edge, no ack for the in-flight request.

Configuration
REQ-036 Macro MEMORY_ARBITER_TIMEOUT_EN: when defined, a watchdog counts memReq-high cycles; on reaching TIMEOUT_CYCLES without memReady, SHALL abort: ack pulse, data output 0, timeoutError pulse, return to IDLE.
REQ-037 Without MEMORY_ARBITER_TIMEOUT_EN: SHALL wait indefinitely for memReady; timeoutError SHALL be tied 0; TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-038 Package memory_arbiter_pkg SHALL hold the state enum (IDLE/FETCH/DATA), the grant-owner constants and the default widths.
REQ-039 SHALL instantiate sub-module memory_arbiter_watchdog (counter, clear, expire) only under MEMORY_ARBITER_TIMEOUT_EN.

Verification
REQ-040 Fetch 0x10, memReady after 3 memReq cycles with 0xDEADBEEF: memReq high 3 cycles, one fetchAck, fetchData=0xDEADBEEF.
REQ-041 Both requests on the first cycle after reset: data acked first, then fetch; never both acks in one cycle.
REQ-042 Both requests held continuously for 4 transactions: grant order DATA, FETCH, DATA, FETCH.
REQ-043 Store 0x12345678 to 0x20: memWrite=1, memAddr=0x20, memWriteData=0x12345678; dataAck pulses; dataReadData unchanged.
REQ-044 resetN=0 during DATA while memReady=0: next cycle memReq=0 and busy=0; no ack ever issued.
REQ-045 With macro, TIMEOUT_CYCLES=16, memReady held 0: after 16 memReq cycles, dataAck and timeoutError pulse together, dataReadData=0; without macro, still waiting at cycle 100.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package memory_arbiter_pkg;

    localparam int DEFAULT_ADDR_W         = 32;
    localparam int DEFAULT_DATA_W         = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    // Identifies which requester owned the most recent completed grant.
    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/memory_arbiter_watchdog.sv
// Counts cycles spent waiting on memory; expire flags the final allowed cycle.
// Only instantiated when MEMORY_ARBITER_TIMEOUT_EN is defined.
module memory_arbiter_watchdog
    import memory_arbiter_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 8'd1;
        end
    end

    // High during the LIMIT-th consecutive counted cycle.
    assign expire = count_en && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory port.
// Define MEMORY_ARBITER_TIMEOUT_EN to enable the memReady watchdog.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              fetchReq,
    input  logic [ADDR_W-1:0] fetchAddr,
    output logic              fetchAck,
    output logic [DATA_W-1:0] fetchData,
    input  logic              dataReq,
    input  logic              dataWrite,
    input  logic [ADDR_W-1:0] dataAddr,
    input  logic [DATA_W-1:0] dataWriteData,
    output logic              dataAck,
    output logic [DATA_W-1:0] dataReadData,
    output logic              memReq,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWriteData,
    input  logic [DATA_W-1:0] memReadData,
    input  logic              memReady,
    output logic              busy,
    output logic              timeoutError
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("memory_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end

    state_t state;
    owner_t last_grant;
    logic   fetch_pending;
    logic   data_pending;
    logic   grant_fetch;
    logic   grant_data;
    logic   finish;
    logic   timed_out;

    // A requester whose ack is on the bus this cycle is still holding its
    // request line; it only becomes eligible again one cycle later.
    assign fetch_pending = fetchReq && !fetchAck;
    assign data_pending  = dataReq && !dataAck;
    assign grant_data    = data_pending && (!fetch_pending || last_grant == OWNER_FETCH);
    assign grant_fetch   = fetch_pending && !grant_data;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    logic expire;

    memory_arbiter_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (resetN),
        .clear    (!memReq),
        .count_en (memReq),
        .expire   (expire)
    );

    assign timed_out = expire && !memReady;
`else
    assign timed_out = 1'b0;
`endif

    assign finish = memReady || timed_out;

    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; mixing in = would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state        <= IDLE;
            last_grant   <= OWNER_FETCH;
            fetchAck     <= 1'b0;
            fetchData    <= '0;
            dataAck      <= 1'b0;
            dataReadData <= '0;
            memReq       <= 1'b0;
            memWrite     <= 1'b0;
            memAddr      <= '0;
            memWriteData <= '0;
            busy         <= 1'b0;
            timeoutError <= 1'b0;
        end else begin
            fetchAck     <= 1'b0;
            dataAck      <= 1'b0;
            timeoutError <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state        <= DATA;
                        busy         <= 1'b1;
                        memReq       <= 1'b1;
                        memWrite     <= dataWrite;
                        memAddr      <= dataAddr;
                        memWriteData <= dataWriteData;
                    end else if (grant_fetch) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        memReq   <= 1'b1;
                        memWrite <= 1'b0;
                        memAddr  <= fetchAddr;
                    end
                end

                FETCH, DATA: begin
                    if (finish) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        memReq       <= 1'b0;
                        memWrite     <= 1'b0;
                        timeoutError <= timed_out;
                        if (state == FETCH) begin
                            last_grant <= OWNER_FETCH;
                            fetchAck   <= 1'b1;
                            fetchData  <= timed_out ? '0 : memReadData;
                        end else begin
                            last_grant <= OWNER_DATA;
                            dataAck    <= 1'b1;
                            // A completed store leaves the last load result in place.
                            if (timed_out) begin
                                dataReadData <= '0;
                            end else if (!memWrite) begin
                                dataReadData <= memReadData;
                            end
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    memReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: memory-side and ack-side expectation
// queues checked by independent monitor processes.
`timescale 1ns/1ps
module tb_memory_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_ack;
    logic [DW-1:0] fetch_data;
    logic          data_req = 1'b0;
    logic          data_write = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_ack;
    logic [DW-1:0] data_read_data;
    logic          mem_req;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data = '0;
    logic          mem_ready = 1'b0;
    logic          busy;
    logic          timeout_error;

    always #5 clk = ~clk;

    memory_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .fetchReq      (fetch_req),
        .fetchAddr     (fetch_addr),
        .fetchAck      (fetch_ack),
        .fetchData     (fetch_data),
        .dataReq       (data_req),
        .dataWrite     (data_write),
        .dataAddr      (data_addr),
        .dataWriteData (data_wdata),
        .dataAck       (data_ack),
        .dataReadData  (data_read_data),
        .memReq        (mem_req),
        .memWrite      (mem_write),
        .memAddr       (mem_addr),
        .memWriteData  (mem_write_data),
        .memReadData   (mem_read_data),
        .memReady      (mem_ready),
        .busy          (busy),
        .timeoutError  (timeout_error)
    );

    // cycles: expected memReq-high cycles (0 = do not check); stall: never ready.
    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        int            cycles;
        logic          stall;
        logic [DW-1:0] rdata;
    } mem_exp_t;

    // keep: the data output must be unchanged from its previous value.
    typedef struct {
        logic          is_data;
        logic          keep;
        logic [DW-1:0] data;
        logic          timeout;
    } resp_exp_t;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_mem(input logic [AW-1:0] addr, input logic write, input logic [DW-1:0] wdata,
                            input int cycles, input logic stall, input logic [DW-1:0] rdata);
        mem_exp_t e;
        e.addr = addr; e.write = write; e.wdata = wdata;
        e.cycles = cycles; e.stall = stall; e.rdata = rdata;
        mem_q.push_back(e);
    endtask

    task automatic push_resp(input logic is_data, input logic keep, input logic [DW-1:0] data, input logic timeout);
        resp_exp_t e;
        e.is_data = is_data; e.keep = keep; e.data = data; e.timeout = timeout;
        resp_q.push_back(e);
    endtask

    // Memory responder: checks each new memory request and answers it.
    mem_exp_t cur;
    logic     cur_valid = 1'b0;
    int       req_cycles = 0;
    logic     idle_noise = 1'b0;

    always @(negedge clk) begin
        if (mem_req) begin
            if (req_cycles == 0) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_req", 64'(mem_req), 64'(0));
                    cur_valid = 1'b0;
                end else begin
                    cur = mem_q.pop_front();
                    cur_valid = 1'b1;
                    check("mem_addr", 64'(mem_addr), 64'(cur.addr));
                    check("mem_write", 64'(mem_write), 64'(cur.write));
                    if (cur.write) check("mem_write_data", 64'(mem_write_data), 64'(cur.wdata));
                end
            end
            req_cycles++;
            mem_ready     = cur_valid && !cur.stall && (req_cycles >= cur.cycles);
            mem_read_data = mem_ready ? cur.rdata : 32'h0BAD_0BAD;
        end else begin
            if (cur_valid && cur.cycles > 0) check("mem_req_cycles", 64'(req_cycles), 64'(cur.cycles));
            cur_valid     = 1'b0;
            req_cycles    = 0;
            mem_ready     = idle_noise;
            mem_read_data = 32'hFFFF_FFFF;
        end
    end

    // Ack monitor with a model of the held data outputs.
    logic [DW-1:0] m_fetch = '0;
    logic [DW-1:0] m_data  = '0;
    logic          rst_prev = 1'b0;

    always @(negedge clk) begin
        resp_exp_t e;
        logic [DW-1:0] expv;
        if (!rst_prev) begin
            m_fetch = '0;
            m_data  = '0;
        end
        rst_prev = resetN;
        if (fetch_ack && data_ack) check("dual_ack", 64'({fetch_ack, data_ack}), 64'(2'b00));
        if (fetch_ack || data_ack) begin
            if (resp_q.size() == 0) begin
                check("unexpected_ack", 64'({fetch_ack, data_ack}), 64'(2'b00));
            end else begin
                e = resp_q.pop_front();
                check("ack_is_data", 64'(data_ack), 64'(e.is_data));
                check("ack_timeout_error", 64'(timeout_error), 64'(e.timeout));
                if (e.is_data) begin
                    expv = e.keep ? m_data : e.data;
                    check("data_read_data", 64'(data_read_data), 64'(expv));
                    m_data = expv;
                end else begin
                    expv = e.keep ? m_fetch : e.data;
                    check("fetch_data", 64'(fetch_data), 64'(expv));
                    m_fetch = expv;
                end
            end
        end else begin
            check("timeout_error_no_ack", 64'(timeout_error), 64'(0));
            check("fetch_data_hold", 64'(fetch_data), 64'(m_fetch));
            check("data_read_data_hold", 64'(data_read_data), 64'(m_data));
        end
    end

    // Requester: sole driver of the request lines; raises on issue, drops on ack.
    int fetch_issued = 0, fetch_taken = 0;
    int data_issued  = 0, data_taken  = 0;
    int abort_issued = 0, abort_taken = 0;
    int total_acks = 0;
    int hold_until = 0;

    always @(negedge clk) begin
        if (fetch_ack || data_ack) begin
            total_acks++;
            if (total_acks == hold_until) begin
                fetch_req = 1'b0;
                data_req  = 1'b0;
            end else if (total_acks > hold_until) begin
                if (fetch_ack) fetch_req = 1'b0;
                if (data_ack)  data_req  = 1'b0;
            end
        end
        if (abort_issued != abort_taken) begin
            abort_taken = abort_issued;
            fetch_req = 1'b0;
            data_req  = 1'b0;
        end
        if (fetch_issued != fetch_taken) begin fetch_taken = fetch_issued; fetch_req = 1'b1; end
        if (data_issued  != data_taken)  begin data_taken  = data_issued;  data_req  = 1'b1; end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((resp_q.size() != 0 || fetch_req || data_req) && n < budget) begin
            tick();
            n++;
        end
        check("wait_within_budget", 64'(n < budget), 64'(1));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        repeat (3) tick();
        @(negedge clk); #1;
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_fetch_ack", 64'(fetch_ack), 64'(0));
        check("rst_data_ack", 64'(data_ack), 64'(0));
        check("rst_fetch_data", 64'(fetch_data), 64'(0));
        check("rst_data_read_data", 64'(data_read_data), 64'(0));
        check("rst_mem_write", 64'(mem_write), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_write_data", 64'(mem_write_data), 64'(0));
        check("rst_timeout_error", 64'(timeout_error), 64'(0));
        tick();
        resetN = 1'b1;
        tick();

        // Fetch with memReady on the third memReq cycle.
        push_mem(32'h10, 1'b0, '0, 3, 1'b0, 32'hDEAD_BEEF);
        push_resp(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        fetch_addr = 32'h10;
        fetch_issued++;
        wait_done(30);

        // Minimum latency: request cycle, memReq cycle, ack cycle.
        push_mem(32'h14, 1'b0, '0, 1, 1'b0, 32'h0000_1414);
        push_resp(1'b0, 1'b0, 32'h0000_1414, 1'b0);
        fetch_addr = 32'h14;
        fetch_issued++;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!fetch_ack && n < 10);
        check("fetch_latency_edges", 64'(n), 64'(2));
        wait_done(30);

        // Load.
        push_mem(32'h40, 1'b0, '0, 2, 1'b0, 32'hCAFE_F00D);
        push_resp(1'b1, 1'b0, 32'hCAFE_F00D, 1'b0);
        data_write = 1'b0;
        data_addr  = 32'h40;
        data_issued++;
        wait_done(30);

        // Store leaves the load result alone.
        push_mem(32'h20, 1'b1, 32'h1234_5678, 1, 1'b0, 32'h0BAD_F00D);
        push_resp(1'b1, 1'b1, '0, 1'b0);
        data_write = 1'b1;
        data_addr  = 32'h20;
        data_wdata = 32'h1234_5678;
        data_issued++;
        wait_done(30);
        check("store_keeps_read_data", 64'(data_read_data), 64'(32'hCAFE_F00D));
        data_write = 1'b0;

        // memReady with no memory request outstanding.
        idle_noise = 1'b1;
        repeat (5) tick();
        check("noise_mem_req", 64'(mem_req), 64'(0));
        check("noise_busy", 64'(busy), 64'(0));
        idle_noise = 1'b0;
        tick();

        // Both requests on the first cycle after reset: data wins the tie.
        resetN = 1'b0;
        repeat (2) tick();
        push_mem(32'h100, 1'b0, '0, 1, 1'b0, 32'h1111_1111);
        push_mem(32'h200, 1'b0, '0, 2, 1'b0, 32'h2222_2222);
        push_resp(1'b1, 1'b0, 32'h1111_1111, 1'b0);
        push_resp(1'b0, 1'b0, 32'h2222_2222, 1'b0);
        data_addr  = 32'h100;
        fetch_addr = 32'h200;
        resetN = 1'b1;
        fetch_issued++;
        data_issued++;
        wait_done(30);

        // Both held for four transactions: DATA, FETCH, DATA, FETCH.
        push_mem(32'h400, 1'b0, '0, 1, 1'b0, 32'hA1A1_A1A1);
        push_mem(32'h300, 1'b0, '0, 1, 1'b0, 32'hB1B1_B1B1);
        push_mem(32'h400, 1'b0, '0, 2, 1'b0, 32'hA2A2_A2A2);
        push_mem(32'h300, 1'b0, '0, 1, 1'b0, 32'hB2B2_B2B2);
        push_resp(1'b1, 1'b0, 32'hA1A1_A1A1, 1'b0);
        push_resp(1'b0, 1'b0, 32'hB1B1_B1B1, 1'b0);
        push_resp(1'b1, 1'b0, 32'hA2A2_A2A2, 1'b0);
        push_resp(1'b0, 1'b0, 32'hB2B2_B2B2, 1'b0);
        data_addr  = 32'h400;
        fetch_addr = 32'h300;
        hold_until = total_acks + 4;
        fetch_issued++;
        data_issued++;
        wait_done(60);

        // Reset in the middle of a stalled load: silent abort.
        push_mem(32'h500, 1'b0, '0, 0, 1'b1, '0);
        data_addr = 32'h500;
        data_issued++;
        repeat (3) tick();
        check("abort_setup_mem_req", 64'(mem_req), 64'(1));
        resetN = 1'b0;
        abort_issued++;
        @(posedge clk);
        @(negedge clk); #1;
        check("abort_mem_req", 64'(mem_req), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        tick();
        resetN = 1'b1;
        repeat (10) tick();

        // Load after abort, giving the watchdog test a nonzero prior value.
        push_mem(32'h700, 1'b0, '0, 1, 1'b0, 32'h5A5A_5A5A);
        push_resp(1'b1, 1'b0, 32'h5A5A_5A5A, 1'b0);
        data_addr = 32'h700;
        data_issued++;
        wait_done(30);

        // memReady never arrives.
        data_addr = 32'h600;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        push_mem(32'h600, 1'b0, '0, TO, 1'b1, '0);
        push_resp(1'b1, 1'b0, '0, 1'b1);
        data_issued++;
        wait_done(60);
`else
        push_mem(32'h600, 1'b0, '0, 0, 1'b1, '0);
        data_issued++;
        repeat (100) tick();
        check("no_timeout_mem_req", 64'(mem_req), 64'(1));
        check("no_timeout_busy", 64'(busy), 64'(1));
        check("no_timeout_data_ack", 64'(data_ack), 64'(0));
        resetN = 1'b0;
        abort_issued++;
        repeat (2) tick();
        resetN = 1'b1;
        tick();
`endif

        check("mem_q_drained", 64'(mem_q.size()), 64'(0));
        check("resp_q_drained", 64'(resp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
